// File: rtl/wired_dsram_arb_if.sv
// Bundle of the three requester ports and the SRAM command/response port of the dcache bank arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface wired_dsram_arb_if #(
  parameter int TAG_W = 24
);
  // refill write requester
  logic                 rfl_valid_i;
  logic                 rfl_ready_o;
  logic [9:0]           rfl_addr_i;
  logic [1:0]           rfl_way_i;
  logic [31:0]          rfl_wdata_i;
  logic                 rfl_tag_we_i;
  logic [TAG_W-1:0]     rfl_wtag_i;
  // snoop tag-read requester
  logic                 snp_valid_i;
  logic                 snp_ready_o;
  logic [9:0]           snp_addr_i;
  logic                 snp_resp_valid_o;
  logic [4*TAG_W-1:0]   snp_rtag_o;
  // LSU read requester
  logic                 lsu_valid_i;
  logic                 lsu_ready_o;
  logic [9:0]           lsu_addr_i;
  logic                 lsu_resp_valid_o;
  logic [127:0]         lsu_rdata_o;
  logic [4*TAG_W-1:0]   lsu_rtag_o;
  // SRAM macro
  logic [9:0]           sram_addr_o;
  logic                 sram_re_o;
  logic                 sram_we_o;
  logic                 sram_tag_we_o;
  logic [1:0]           sram_way_o;
  logic [31:0]          sram_wdata_o;
  logic [TAG_W-1:0]     sram_wtag_o;
  logic [127:0]         sram_rdata_i;
  logic [4*TAG_W-1:0]   sram_rtag_i;

  modport slave (
    input  rfl_valid_i, rfl_addr_i, rfl_way_i, rfl_wdata_i, rfl_tag_we_i, rfl_wtag_i,
    output rfl_ready_o,
    input  snp_valid_i, snp_addr_i,
    output snp_ready_o, snp_resp_valid_o, snp_rtag_o,
    input  lsu_valid_i, lsu_addr_i,
    output lsu_ready_o, lsu_resp_valid_o, lsu_rdata_o, lsu_rtag_o,
    output sram_addr_o, sram_re_o, sram_we_o, sram_tag_we_o, sram_way_o, sram_wdata_o, sram_wtag_o,
    input  sram_rdata_i, sram_rtag_i
  );

  modport master (
    output rfl_valid_i, rfl_addr_i, rfl_way_i, rfl_wdata_i, rfl_tag_we_i, rfl_wtag_i,
    input  rfl_ready_o,
    output snp_valid_i, snp_addr_i,
    input  snp_ready_o, snp_resp_valid_o, snp_rtag_o,
    output lsu_valid_i, lsu_addr_i,
    input  lsu_ready_o, lsu_resp_valid_o, lsu_rdata_o, lsu_rtag_o,
    input  sram_addr_o, sram_re_o, sram_we_o, sram_tag_we_o, sram_way_o, sram_wdata_o, sram_wtag_o,
    output sram_rdata_i, sram_rtag_i
  );
endinterface

// File: rtl/wired_dsram_arb.sv
// Single-port dcache SRAM arbiter: refill > snoop > LSU with LSU starvation promotion,
// one combinational SRAM command per cycle and a 1-cycle read-response router.
module wired_dsram_arb #(
  parameter int TAG_W        = 24,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic               clk,
  input  logic               rst,
  wired_dsram_arb_if.slave   bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_SNP  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  owner_e            resp_owner_q, resp_owner_d;
  logic [9:0]        addr_q, addr_d;
  logic [1:0]        way_q, way_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [TAG_W-1:0]  wtag_q, wtag_d;

  logic lsu_promote;
  logic gnt_rfl, gnt_snp, gnt_lsu;

  // Grants depend only on the valids, the starvation state and reset.
  always_comb begin
    lsu_promote = bus.lsu_valid_i && (starve_cnt_q == LIMIT);
    gnt_rfl     = !rst && bus.rfl_valid_i && !lsu_promote;
    gnt_snp     = !rst && bus.snp_valid_i && !bus.rfl_valid_i && !lsu_promote;
    gnt_lsu     = !rst && bus.lsu_valid_i &&
                  (lsu_promote || (!bus.rfl_valid_i && !bus.snp_valid_i));
  end

  assign bus.rfl_ready_o = gnt_rfl;
  assign bus.snp_ready_o = gnt_snp;
  assign bus.lsu_ready_o = gnt_lsu;

  // SRAM command; payload fields hold their last driven value when idle.
  always_comb begin
    bus.sram_re_o     = 1'b0;
    bus.sram_we_o     = 1'b0;
    bus.sram_tag_we_o = 1'b0;
    addr_d            = addr_q;
    way_d             = way_q;
    wdata_d           = wdata_q;
    wtag_d            = wtag_q;
    if (gnt_rfl) begin
      bus.sram_we_o     = 1'b1;
      bus.sram_tag_we_o = bus.rfl_tag_we_i;
      addr_d            = bus.rfl_addr_i;
      way_d             = bus.rfl_way_i;
      wdata_d           = bus.rfl_wdata_i;
      wtag_d            = bus.rfl_wtag_i;
    end else if (gnt_snp) begin
      bus.sram_re_o = 1'b1;
      addr_d        = bus.snp_addr_i;
    end else if (gnt_lsu) begin
      bus.sram_re_o = 1'b1;
      addr_d        = bus.lsu_addr_i;
    end
  end

  assign bus.sram_addr_o  = addr_d;
  assign bus.sram_way_o   = way_d;
  assign bus.sram_wdata_o = wdata_d;
  assign bus.sram_wtag_o  = wtag_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.lsu_valid_i || gnt_lsu) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    resp_owner_d = OWN_NONE;
    if (gnt_snp) begin
      resp_owner_d = OWN_SNP;
    end else if (gnt_lsu) begin
      resp_owner_d = OWN_LSU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      resp_owner_q <= OWN_NONE;
      addr_q       <= '0;
      way_q        <= '0;
      wdata_q      <= '0;
      wtag_q       <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      resp_owner_q <= resp_owner_d;
      addr_q       <= addr_d;
      way_q        <= way_d;
      wdata_q      <= wdata_d;
      wtag_q       <= wtag_d;
    end
  end

  // Read data passes straight through; only the valids are owner-qualified.
  assign bus.snp_resp_valid_o = (resp_owner_q == OWN_SNP);
  assign bus.lsu_resp_valid_o = (resp_owner_q == OWN_LSU);
  assign bus.snp_rtag_o       = bus.sram_rtag_i;
  assign bus.lsu_rdata_o      = bus.sram_rdata_i;
  assign bus.lsu_rtag_o       = bus.sram_rtag_i;

endmodule
